// File: rtl/clock_divider_mc_if.sv
// Bus bundle for clock_divider_mc: per-channel enable/load/config inputs and the
// per-channel divided clock, tick strobe and pending-commit flag.
interface clock_divider_mc_if #(
    parameter int CH = 4,
    parameter int W  = 16
);
    logic [CH-1:0]   en_i;
    logic [CH-1:0]   load_i;
    logic [CH*W-1:0] div_i;
    logic [CH*W-1:0] high_i;
    logic [CH-1:0]   clk_o;
    logic [CH-1:0]   tick_o;
    logic [CH-1:0]   pend_o;

    modport master (
        output en_i, load_i, div_i, high_i,
        input  clk_o, tick_o, pend_o
    );

    modport slave (
        input  en_i, load_i, div_i, high_i,
        output clk_o, tick_o, pend_o
    );
endinterface

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock-enable generator with shadowed period/high-time
// registers committed at period boundaries. Define SYNC_EN to add the sync_i phase-align input.
module clock_divider_mc #(
    parameter int CH       = 4,
    parameter int W        = 16,
    parameter int DEF_DIV  = 50,
    parameter int DEF_HIGH = 25
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SYNC_EN
    input  logic sync_i,
`endif
    clock_divider_mc_if.slave bus
);

    localparam logic [W-1:0] DEF_DIV_V  = W'(DEF_DIV);
    localparam logic [W-1:0] DEF_HIGH_V = W'(DEF_HIGH);

    logic [W-1:0]  div_q   [CH];
    logic [W-1:0]  div_d   [CH];
    logic [W-1:0]  high_q  [CH];
    logic [W-1:0]  high_d  [CH];
    logic [W-1:0]  sdiv_q  [CH];
    logic [W-1:0]  sdiv_d  [CH];
    logic [W-1:0]  shigh_q [CH];
    logic [W-1:0]  shigh_d [CH];
    logic [W-1:0]  cnt_q   [CH];
    logic [W-1:0]  cnt_d   [CH];
    logic [CH-1:0] run_q, run_d;
    logic [CH-1:0] clk_q, clk_d;
    logic [CH-1:0] tick_q, tick_d;
    logic [CH-1:0] pend_q, pend_d;

    // Clamp keeps a committed setting producing a real square wave: period >= 2, 1 <= high < period.
    function automatic logic [2*W-1:0] clamp_cfg(input logic [W-1:0] d, input logic [W-1:0] h);
        logic [W-1:0] de;
        logic [W-1:0] he;
        de = (d < W'(2)) ? W'(2) : d;
        he = (h == '0) ? W'(1) : h;
        if (he > de - W'(1)) he = de - W'(1);
        return {de, he};
    endfunction

    always_comb begin
        logic [W-1:0]   ld_div;
        logic [W-1:0]   ld_high;
        logic [W-1:0]   cnt_inc;
        logic [2*W-1:0] cfg;
        logic           bound;
        logic           commit;

        div_d   = div_q;
        high_d  = high_q;
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        clk_d   = clk_q;
        tick_d  = tick_q;
        pend_d  = pend_q;
        ld_div  = '0;
        ld_high = '0;
        cnt_inc = '0;
        cfg     = '0;
        bound   = 1'b0;
        commit  = 1'b0;

        for (int c = 0; c < CH; c++) begin
            // A load on this edge is visible to a commit on the same edge (bypass).
            ld_div  = bus.load_i[c] ? bus.div_i[c*W +: W]  : sdiv_q[c];
            ld_high = bus.load_i[c] ? bus.high_i[c*W +: W] : shigh_q[c];
            cnt_inc = cnt_q[c] + W'(1);
            bound   = (cnt_q[c] == div_q[c] - W'(1));
`ifdef SYNC_EN
            bound   = bound | sync_i;
`endif
            commit  = 1'b0;

            if (!bus.en_i[c]) begin
                run_d[c]  = 1'b0;
                cnt_d[c]  = '0;
                clk_d[c]  = 1'b0;
                tick_d[c] = 1'b0;
                commit    = 1'b1;
            end else if (!run_q[c]) begin
                run_d[c]  = 1'b1;
                cnt_d[c]  = '0;
                clk_d[c]  = 1'b1;
                tick_d[c] = 1'b1;
            end else if (bound) begin
                cnt_d[c]  = '0;
                clk_d[c]  = 1'b1;
                tick_d[c] = 1'b1;
                commit    = 1'b1;
            end else begin
                cnt_d[c]  = cnt_inc;
                clk_d[c]  = (cnt_inc < high_q[c]);
                tick_d[c] = 1'b0;
            end

            sdiv_d[c]  = ld_div;
            shigh_d[c] = ld_high;
            cfg        = clamp_cfg(ld_div, ld_high);
            if (commit) begin
                div_d[c]  = cfg[2*W-1:W];
                high_d[c] = cfg[W-1:0];
                pend_d[c] = 1'b0;
            end else if (bus.load_i[c]) begin
                pend_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                div_q[c]   <= DEF_DIV_V;
                high_q[c]  <= DEF_HIGH_V;
                sdiv_q[c]  <= DEF_DIV_V;
                shigh_q[c] <= DEF_HIGH_V;
                cnt_q[c]   <= '0;
            end
            run_q  <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            div_q   <= div_d;
            high_q  <= high_d;
            sdiv_q  <= sdiv_d;
            shigh_q <= shigh_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.clk_o  = clk_q;
    assign bus.tick_o = tick_q;
    assign bus.pend_o = pend_q;

endmodule
